// File: rtl/network_output_decoder.sv
// ============================================================================
// network_output_decoder: sequential signed argmax over one output vector, results queued in a FWFT FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module network_output_decoder #(
  parameter int WIDTH       = 8,
  parameter int NUM_OUTPUTS = 10,
  parameter int FIFO_DEPTH  = 4,
  localparam int IDX_W      = $clog2(NUM_OUTPUTS),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] VALUES_IN [NUM_OUTPUTS],
  input  logic                    VALID_IN,
  output logic                    BUSY,
  output logic [IDX_W-1:0]        CLASS_OUT,
  output logic signed [WIDTH-1:0] SCORE_OUT,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    OVERFLOW,
  output logic [7:0]              DROP_COUNT,
  output logic [LVL_W-1:0]        FIFO_LEVEL
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_PUSH = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic signed [WIDTH-1:0] vals [NUM_OUTPUTS];
  logic signed [WIDTH-1:0] best;
  logic [IDX_W-1:0]        best_idx;
  logic [IDX_W-1:0]        idx;
  logic                    scan_last;
  logic                    capture;
  logic                    sample_drop;
  logic                    push_req;

  assign scan_last = (idx == IDX_W'(NUM_OUTPUTS - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (VALID_IN) state_next = S_SCAN;
      S_SCAN:  if (scan_last) state_next = S_PUSH;
      S_PUSH:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY        = (state != S_IDLE);
    capture     = (state == S_IDLE) && VALID_IN;
    sample_drop = (state != S_IDLE) && VALID_IN;
    push_req    = (state == S_PUSH);
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge CLK) begin
    if (RST) begin
      best     <= '0;
      best_idx <= '0;
      idx      <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) vals[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) vals[i] <= VALUES_IN[i];
      best     <= VALUES_IN[0];
      best_idx <= '0;
      idx      <= IDX_W'(1);
    end else if (state == S_SCAN) begin
      if (vals[idx] > best) begin
        best     <= vals[idx];
        best_idx <= idx;
      end
      if (!scan_last) idx <= idx + IDX_W'(1);
    end
  end

  logic [IDX_W-1:0]        fifo_class [FIFO_DEPTH];
  logic signed [WIDTH-1:0] fifo_score [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [LVL_W-1:0]        level;
  logic [IDX_W-1:0]        last_class;
  logic signed [WIDTH-1:0] last_score;
  logic                    pop;
  logic                    full;
  logic                    push_ok;
  logic                    result_drop;
  logic [1:0]              drop_inc;
  logic [8:0]              drop_sum;

  assign OUT_VALID   = (level != '0);
  assign FIFO_LEVEL  = level;
  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign pop         = OUT_VALID && OUT_READY;
  // A full FIFO still takes the result when the head leaves in the same cycle.
  assign push_ok     = push_req && (!full || pop);
  assign result_drop = push_req && !push_ok;
  assign CLASS_OUT   = OUT_VALID ? fifo_class[rd_ptr] : last_class;
  assign SCORE_OUT   = OUT_VALID ? fifo_score[rd_ptr] : last_score;
  assign drop_inc    = {1'b0, sample_drop} + {1'b0, result_drop};
  assign drop_sum    = {1'b0, DROP_COUNT} + {7'd0, drop_inc};

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_class[wr_ptr] <= best_idx;
      fifo_score[wr_ptr] <= best;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      last_class <= '0;
      last_score <= '0;
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        last_class <= fifo_class[rd_ptr];
        last_score <= fifo_score[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      OVERFLOW   <= sample_drop || result_drop;
      DROP_COUNT <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_network_output_decoder.sv
// Self-checking bench for network_output_decoder: directed scenarios plus random traffic against a queue-based model.
`default_nettype none

module tb_network_output_decoder;

  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              valid_in;
  logic              out_ready;
  logic signed [7:0] vals [N];
  logic              busy;
  logic [1:0]        class_out;
  logic signed [7:0] score_out;
  logic              out_valid;
  logic              overflow;
  logic [7:0]        drop_count;
  logic [1:0]        fifo_level;

  network_output_decoder #(
    .WIDTH(8),
    .NUM_OUTPUTS(N),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .VALUES_IN(vals),
    .VALID_IN(valid_in),
    .BUSY(busy),
    .CLASS_OUT(class_out),
    .SCORE_OUT(score_out),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OVERFLOW(overflow),
    .DROP_COUNT(drop_count),
    .FIFO_LEVEL(fifo_level)
  );

  typedef struct {
    int cls;
    int score;
  } res_t;

  // Model: busy countdown (N non-idle cycles per accepted vector, result due on the last), FIFO as a queue.
  int   m_busy;
  res_t m_pend;
  res_t m_last;
  res_t m_q[$];
  int   m_drops;
  int   m_ovf;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t winner();
    res_t r;
    int   b = 0;
    for (int i = 1; i < N; i++) if (vals[i] > vals[b]) b = i;
    r.cls   = b;
    r.score = int'(vals[b]);
    return r;
  endfunction

  task automatic compare_outputs();
    res_t head;
    head = (m_q.size() > 0) ? m_q[0] : m_last;
    check_val("busy", int'(busy), int'(m_busy != 0));
    check_val("out_valid", int'(out_valid), int'(m_q.size() > 0));
    check_val("class_out", int'(class_out), head.cls);
    check_val("score_out", int'(score_out), head.score);
    check_val("overflow", int'(overflow), m_ovf);
    check_val("drop_count", int'(drop_count), m_drops);
    check_val("fifo_level", int'(fifo_level), m_q.size());
  endtask

  task automatic model_update();
    int d;
    bit was_idle;
    bit do_push;
    bit pop;
    bit ok;
    if (rst) begin
      m_busy  = 0;
      m_q.delete();
      m_last  = '{0, 0};
      m_drops = 0;
      m_ovf   = 0;
    end else begin
      d        = 0;
      was_idle = (m_busy == 0);
      do_push  = (m_busy == 1);
      pop      = (m_q.size() > 0) && out_ready;
      ok       = (m_q.size() < DEPTH) || pop;
      if (!was_idle && valid_in) d++;
      if (pop) m_last = m_q.pop_front();
      if (do_push) begin
        if (ok) m_q.push_back(m_pend);
        else d++;
      end
      if (was_idle) begin
        if (valid_in) begin
          m_pend = winner();
          m_busy = N;
        end
      end else begin
        m_busy--;
      end
      m_ovf   = (d > 0) ? 1 : 0;
      m_drops = (m_drops + d > 255) ? 255 : m_drops + d;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    vals[0] = 8'(a);
    vals[1] = 8'(b);
    vals[2] = 8'(c);
    vals[3] = 8'(d);
  endtask

  task automatic pulse(input int a, input int b, input int c, input int d);
    set_vec(a, b, c, d);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    valid_in  = 1'b0;
    out_ready = 1'b1;
    set_vec(0, 0, 0, 0);
    m_busy = 0; m_last = '{0, 0}; m_drops = 0; m_ovf = 0;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Basic decode with a tie: first valid output expected 5 cycles after the strobe.
    pulse(-3, 5, 2, 5);
    k = 1;
    while (k < 20 && !out_valid) begin
      step();
      k++;
    end
    check_val("t1_latency", k, 5);
    check_val("t1_class", int'(class_out), 1);
    check_val("t1_score", int'(score_out), 5);
    idle(2);
    check_val("t1_level", int'(fifo_level), 0);

    // Signed compares, all-equal minimum.
    pulse(-128, -1, -7, -2);
    idle(6);
    pulse(-128, -128, -128, -128);
    idle(6);

    // Sample arriving while busy is dropped.
    pulse(0, 0, 9, 0);
    step();
    pulse(7, 0, 0, 0);
    idle(8);
    check_val("t3_drops", int'(drop_count), 1);

    // FIFO full: third result dropped, then drain.
    out_ready = 1'b0;
    pulse(9, 1, 1, 1);  idle(5);
    pulse(1, 9, 1, 1);  idle(5);
    pulse(1, 1, 9, 1);  idle(5);
    check_val("t4_level", int'(fifo_level), 2);
    check_val("t4_drops", int'(drop_count), 2);
    out_ready = 1'b1;
    idle(3);
    // Full FIFO, pop coincides with the PUSH cycle: no drop.
    out_ready = 1'b0;
    pulse(5, 1, 1, 1);  idle(5);
    pulse(1, 5, 1, 1);  idle(5);
    pulse(1, 1, 5, 1);
    idle(3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle(2);
    check_val("t4_nodrop", int'(drop_count), 2);
    out_ready = 1'b1;
    idle(3);

    // Reset in the middle of a scan.
    pulse(1, 2, 3, 4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(8);
    pulse(4, 3, 2, 1);
    idle(6);

    // Drop counter saturation.
    valid_in = 1'b1;
    idle(400);
    valid_in = 1'b0;
    check_val("t6_sat", int'(drop_count), 255);
    idle(6);

    // Random traffic with occasional resets.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      valid_in  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) vals[i] = 8'($urandom_range(0, 255));
        else vals[i] = 8'(int'($urandom_range(0, 4)) - 2);
      end
      step();
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
